// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl
//   Interrupt aggregation stage for the SoC timers. Each timer match level is
//   edge-detected into a sticky pending flag (IPR). A per-source enable mask
//   (IER) gates the pending flags onto a single level interrupt. A second
//   event on a source that is already pending records an overrun (OVR).
//   Software accesses the block through a zero-wait peripheral bus slave.
//
// Ports
//   clk     : system clock, all state changes on the rising edge
//   rst     : synchronous active-high reset
//   src_i   : timer match levels, one bit per source
//   req     : bus request
//   we      : bus write enable
//   be      : bus byte enables
//   addr    : byte offset within the 4 KiB window
//   wdata   : bus write data
//   gnt     : bus grant, always equal to req
//   rvalid  : response valid, one cycle after every granted access
//   rdata   : registered read data, 0 after writes
//   irq     : level interrupt to the core
//   irq_id  : lowest-numbered enabled pending source, 0 when irq is low
//
// Register map
//   0x000 IER  RW    per-source enable
//   0x004 IPR  RW1C  pending flags
//   0x008 OVR  RW1C  overrun flags
//   0x00C IDR  RO    bit31 = irq, bits[3:0] = irq_id

module timer_irq_ctrl #(
  parameter int SOURCES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SOURCES-1:0] src_i,
  input  logic               req,
  input  logic               we,
  input  logic [3:0]         be,
  input  logic [11:0]        addr,
  input  logic [31:0]        wdata,
  output logic               gnt,
  output logic               rvalid,
  output logic [31:0]        rdata,
  output logic               irq,
  output logic [3:0]         irq_id
);

  localparam logic [11:0] ADDR_IER = 12'h000;
  localparam logic [11:0] ADDR_IPR = 12'h004;
  localparam logic [11:0] ADDR_OVR = 12'h008;
  localparam logic [11:0] ADDR_IDR = 12'h00C;

  logic [SOURCES-1:0] ier;
  logic [SOURCES-1:0] ipr;
  logic [SOURCES-1:0] ovr;
  logic [SOURCES-1:0] src_q;

  logic [SOURCES-1:0] events;
  logic [SOURCES-1:0] active;
  logic [31:0]        byte_mask;
  logic [31:0]        wbits;
  logic [SOURCES-1:0] wsrc;
  logic [SOURCES-1:0] wmask;
  logic               wr_ier;
  logic               wr_ipr;
  logic               wr_ovr;
  logic               rd_en;
  logic [31:0]        rd_val;
  logic               unused_wbits;

  assign gnt = req;

  // Rising edge of a match level; a level held high only fires once.
  assign events = src_i & ~src_q;

  // Byte enables gate write data per lane; only the low SOURCES bits land
  // in the registers, everything above is silently dropped.
  assign byte_mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wbits        = wdata & byte_mask;
  assign wsrc         = wbits[SOURCES-1:0];
  assign wmask        = byte_mask[SOURCES-1:0];
  assign unused_wbits = ^wbits;

  assign wr_ier = req & we & (addr == ADDR_IER);
  assign wr_ipr = req & we & (addr == ADDR_IPR);
  assign wr_ovr = req & we & (addr == ADDR_OVR);
  assign rd_en  = req & ~we;

  // Interrupt outputs depend only on registered state. The loop walks from
  // the top down so the lowest active index is the last one written.
  assign active = ipr & ier;
  assign irq    = |active;

  always_comb begin
    irq_id = '0;
    for (int k = SOURCES - 1; k >= 0; k--) begin
      if (active[k]) irq_id = 4'(k);
    end
  end

  // Read mux uses current register values, so a read always sees the state
  // before any write landing on the same edge.
  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_IER: rd_val[SOURCES-1:0] = ier;
      ADDR_IPR: rd_val[SOURCES-1:0] = ipr;
      ADDR_OVR: rd_val[SOURCES-1:0] = ovr;
      ADDR_IDR: rd_val = {irq, 27'd0, irq_id};
      default:  rd_val = '0;
    endcase
  end

  // Register state. Sets are OR-ed in after the W1C clear so that an event
  // beats a simultaneous clear. Overrun looks at the pre-clear IPR, so a
  // clear racing a repeated event still records the overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      ier   <= '0;
      ipr   <= '0;
      ovr   <= '0;
      src_q <= '0;
    end else begin
      src_q <= src_i;
      if (wr_ier) ier <= (ier & ~wmask) | wsrc;
      ipr <= (ipr & ~(wr_ipr ? wsrc : '0)) | events;
      ovr <= (ovr & ~(wr_ovr ? wsrc : '0)) | (events & ipr);
    end
  end

  // Bus response: every granted access yields rvalid the next cycle. Reads
  // capture the mux output, writes return 0, idle cycles hold the last data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= req;
      if (rd_en)          rdata <= rd_val;
      else if (req && we) rdata <= '0;
    end
  end

endmodule

// File: doc/timer_irq_ctrl.md
# timer_irq_ctrl

Interrupt aggregation stage directly downstream of the SoC timers. It takes the `mtch` status level of up to `SOURCES` timer instances and edge-detects each one into a sticky pending flag. It applies a per-source enable mask, records overruns and drives one level interrupt to the core together with the index of the lowest-numbered active source. Software reaches it through the standard peripheral bus slave port (4 KiB window, 12-bit offset).

## Interface
Parameters:
- `SOURCES`, 4: number of timer match inputs (1..16).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `src_i`  in  SOURCES  timer `mtch` levels, one per timer, synchronous to `clk`.
- `req`  in  1  bus request.
- `we`  in  1  write enable.
- `be`  in  4  byte enables.
- `addr`  in  12  byte offset within the window.
- `wdata`  in  32  write data.
- `gnt`  out  1  bus grant.
- `rvalid`  out  1  response valid.
- `rdata`  out  32  read data.
- `irq`  out  1  interrupt request to the core.
- `irq_id`  out  4  index of the lowest-numbered enabled pending source.

## Operation
Register map; all offsets are 32-bit, and bits at or above SOURCES read 0 and ignore writes:
- 0x000 IER, RW: per-source enable; reset 0.
- 0x004 IPR, RW1C: pending flags; reset 0.
- 0x008 OVR, RW1C: overrun flags; reset 0.
- 0x00C IDR, RO: bit31 = `irq`, bits[3:0] = `irq_id`, all other bits 0.
- Any other offset: reads 0, writes are ignored, and the access still completes.

Event capture:
- A registered copy `src_q` of `src_i` is kept; reset value 0.
- An event on source k is `src_i[k] & ~src_q[k]`, i.e. a rising edge.
- An event sets IPR[k]. The enable bit does not affect capture: pending latches even while IER[k]=0.
- An event while IPR[k] is already 1 sets OVR[k].
- A level held high produces exactly one event.

Clearing and simultaneous events:
- Writing 1 to IPR[k] or OVR[k] clears it; writing 0 has no effect.
- `be` gates each byte lane.
- An event and a W1C on the same bit in the same cycle: the set wins.
- A W1C of IPR[k] in the same cycle as an event on k with IPR[k]=1 leaves IPR[k]=1 and sets OVR[k].

Outputs:
- `irq` = OR over k of (IPR[k] & IER[k]).
- `irq_id` = lowest k with IPR[k] & IER[k]; it is 0 when `irq`=0.
- Both are combinational from registered state, with no path from `src_i` or the bus inputs.

Bus:
- `gnt` = `req` (zero-wait).
- A write takes effect at the clock edge where `req & gnt & we`.
- `rvalid` is asserted the cycle after every granted access, reads and writes alike.
- `rdata` is registered. It holds the value sampled at the grant edge for reads and 0 after writes.

## Timing
- Reset (`rst`=1 at a clock edge) clears the following; outputs show these values from the cycle after that edge:
  - IER, IPR, OVR and `src_q`.
  - `rvalid` to 0 and `rdata` to 0.
  - `irq` to 0 and `irq_id` to 0.
- Reset asserted mid-access drops the pending `rvalid`. A source held high across reset release produces one event on the first post-reset edge, because `src_q` restarts at 0.
- Event latency: `src_i` rises before edge N, IPR is set at edge N, and `irq` asserts in the cycle after edge N (1 cycle).
- Enable latency: an IER write at edge N makes `irq` reflect it after edge N.
- Clear latency: a W1C at edge N deasserts `irq` after edge N, unless the set-wins rule applies.
- Read latency: 1 cycle. Back-to-back accesses are allowed every cycle.
- A read in the same cycle as a write to the same register returns the old value.

## Test plan
- Reset, then read all 4 registers: IER/IPR/OVR/IDR all read 0x0; `irq`=0, `irq_id`=0.
- IER=0x5. Pulse `src_i[2]` for 1 cycle. Expected: IPR=0x4; `irq`=1 one cycle after the edge; IDR=0x8000_0002. Then write IPR=0x4: `irq`=0 the next cycle and IDR=0.
- IER=0x0. Hold `src_i[1]` high for 10 cycles. Expected: IPR=0x2, OVR=0, `irq`=0. Then write IER=0x2: `irq`=1 and `irq_id`=1.
- Two rising edges on `src_i[3]` without a clear: IPR=0x8, OVR=0x8. Writing OVR=0x8 clears OVR; IPR stays 0x8.
- Rising edge on `src_i[0]` in the same cycle as a write of IPR=0x1 while IPR[0]=1: IPR stays 0x1 and OVR becomes 0x1.
- IER=0xF. Edges on sources 3 and 1 in the same cycle: `irq_id`=1. Clear IPR bit 1: `irq_id`=3. Writing IPR with `be`=0x0 leaves IPR unchanged. A read of offset 0x010 returns 0 with `rvalid` one cycle later.
